// File: rtl/cpu_pkg.sv
// cpu_pkg: LEGv8 opcode constants, format decode helpers and hazard FSM state.
package cpu_pkg;

    localparam logic [10:0] OP_LDUR  = 11'b11111000010;
    localparam logic [10:0] OP_STUR  = 11'b11111000000;
    localparam logic [10:0] OP_ADDS  = 11'b10101011000;
    localparam logic [10:0] OP_SUBS  = 11'b11101011000;
    localparam logic [7:0]  OP_CBZ   = 8'b10110100;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B     = 6'b000101;
    localparam logic [5:0]  OP_BL    = 6'b100101;
    localparam logic [4:0]  XZR      = 5'd31;

    typedef enum logic {RUN, STALL} state_t;

    // All helpers take the top 11 bits of the instruction word.
    function automatic logic is_cbz(input logic [10:0] op);
        return op[10:3] == OP_CBZ;
    endfunction

    function automatic logic is_stur(input logic [10:0] op);
        return op == OP_STUR;
    endfunction

    function automatic logic is_d_type(input logic [10:0] op);
        return op == OP_LDUR || op == OP_STUR;
    endfunction

    // ADD/ADDS/SUB/SUBS/AND/ANDS/ORR/EOR register forms.
    function automatic logic is_r_type(input logic [10:0] op);
        return (op[7:3] inside {5'b01010, 5'b01011} && op[2:0] == 3'b000)
            || op == OP_ADDS || op == OP_SUBS;
    endfunction

    // ADDI/ADDIS/SUBI/SUBIS plus ANDI/ANDIS/ORRI/EORI.
    function automatic logic is_i_type(input logic [10:0] op);
        return (op[7:3] == 5'b10001 && op[2:1] == 2'b00) || op[7:2] == 6'b100100;
    endfunction

    // Unconditional and flag branches never read a register.
    function automatic logic is_sourceless_branch(input logic [10:0] op);
        return op[10:5] == OP_B || op[10:5] == OP_BL || op[10:3] == OP_BCOND;
    endfunction

    function automatic logic uses_rn(input logic [10:0] op);
        return (is_r_type(op) || is_d_type(op) || is_i_type(op)) && !is_sourceless_branch(op);
    endfunction

    // XZR is never a real dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return a == b && a != XZR;
    endfunction

endpackage

// File: rtl/hazard_stall_unit_sat_counter.sv
// sat_counter: counter that increments on inc and holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up until every bit is set, then hold.
    always_ff @(posedge clk or posedge reset)
        if (reset) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;

endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use / CBZ stall and taken-branch flush control with perf counters.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      ID_opcode,
    input  logic [31:0]      EX_opcode,
    input  logic [31:0]      MEM_opcode,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic             MEM_MemRead,
    input  logic             branch_taken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    import cpu_pkg::*;

    logic [10:0] id_op;
    logic [4:0]  rn, rm, rt, ex_dst, mem_dst;
    logic        cbz, ex_hits_src, need1, need2, stall, flush;
    state_t      state, next_state;
    logic        remaining, next_remaining;
    logic        unused_bits;

    assign id_op   = ID_opcode[31:21];
    assign rn      = ID_opcode[9:5];
    assign rm      = ID_opcode[20:16];
    assign rt      = ID_opcode[4:0];
    assign ex_dst  = EX_opcode[4:0];
    assign mem_dst = MEM_opcode[4:0];
    assign cbz     = is_cbz(id_op);
    assign unused_bits = ^{ID_opcode[15:10], EX_opcode[31:5], MEM_opcode[31:5]};

    assign ex_hits_src = (uses_rn(id_op) && reg_match(ex_dst, rn))
                      || (is_r_type(id_op) && reg_match(ex_dst, rm))
                      || (is_stur(id_op) && reg_match(ex_dst, rt));

    // CBZ resolves in ID, so a load feeding it cannot be forwarded for two cycles.
    assign need2 = cbz && EX_MemRead && reg_match(ex_dst, rt);
    assign need1 = (!cbz && EX_MemRead && ex_hits_src)
                || (cbz && EX_RegWrite && !EX_MemRead && reg_match(ex_dst, rt))
                || (cbz && MEM_MemRead && reg_match(mem_dst, rt));

    // State register; reset drops any pending second stall cycle.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state     <= RUN;
            remaining <= 1'b0;
        end else begin
            state     <= next_state;
            remaining <= next_remaining;
        end

    // Next state and stall decision; STALL ignores detection for its one cycle.
    always_comb begin
        next_state     = state;
        next_remaining = remaining;
        stall          = 1'b0;
        if (state == STALL) begin
            stall          = 1'b1;
            next_remaining = 1'b0;
            next_state     = RUN;
        end else if (need2) begin
            stall          = 1'b1;
            next_remaining = 1'b1;
            next_state     = STALL;
        end else if (need1) begin
            stall = 1'b1;
        end
    end

    assign flush        = branch_taken && !stall && !reset;
    assign PCWrite      = reset || !stall;
    assign IF_ID_Write  = reset || !stall;
    assign ID_EX_Bubble = !reset && stall;
    assign IF_ID_Flush  = flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall && !reset),
        .count (stall_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush),
        .count (flush_count)
    );

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Stall and flush controller for the 5-stage LEGv8 pipeline. Complements the forwarding path: forwarding delivers producer results to consumers, while this block holds consumers back when a result cannot yet be forwarded (load-use, CBZ operand not ready) and squashes the wrong-path fetch after a taken accelerated branch. It sits beside the IF/ID and ID/EX pipeline registers and drives their write enables, the PC write enable and the ID/EX bubble mux. It also keeps saturating stall and flush performance counters.

## Interface
Parameters:
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- ID_opcode  in  32  instruction in decode (IF/ID register)
- EX_opcode  in  32  instruction in execute (ID/EX register)
- MEM_opcode  in  32  instruction in memory stage (EX/MEM register)
- EX_RegWrite  in  1  EX instruction writes a register
- EX_MemRead  in  1  EX instruction is LDUR
- MEM_MemRead  in  1  MEM instruction is LDUR
- branch_taken  in  1  ID-stage branch resolution says taken (B, BL, CBZ, B.cond)
- PCWrite  out  1  PC update enable
- IF_ID_Write  out  1  IF/ID register write enable
- ID_EX_Bubble  out  1  zero all control fields entering ID/EX
- IF_ID_Flush  out  1  replace the IF/ID contents with a NOP
- stall_count  out  CNT_W  number of stall cycles, saturating
- flush_count  out  CNT_W  number of flush cycles, saturating

## Operation
Decoding of the ID source registers:
- Rn = ID_opcode[9:5] for R-type, D-type and I-type instructions.
- Second source is Rm = [20:16] for R-type, and Rt = [4:0] for STUR and CBZ. CBZ uses only Rt.
- B and BL have no sources. B.cond has no register sources; its flags are forwarded, so it never stalls.
- A register compare never matches when the register is X31.

Producer destinations are EX_opcode[4:0] and MEM_opcode[4:0].

Hazard need N:
- N=2: ID is CBZ, EX_MemRead=1 and the EX destination equals Rt.
- N=1: any one of the following.
  - ID is not CBZ, EX_MemRead=1 and the EX destination matches a source.
  - ID is CBZ, EX_RegWrite=1, EX is not a load, and the EX destination equals Rt.
  - ID is CBZ, MEM_MemRead=1 and the MEM destination equals Rt.
- Otherwise N=0.

FSM states are RUN and STALL, with a 1-bit remaining counter.
- RUN, N=0: no stall. Go to RUN.
- RUN, N=1: stall this cycle. Stay in RUN.
- RUN, N=2: stall this cycle. Go to STALL with remaining=1.
- STALL: stall this cycle and ignore hazard detection. Clear remaining and go to RUN.

Stall this cycle means PCWrite=0, IF_ID_Write=0 and ID_EX_Bubble=1. Otherwise PCWrite=1, IF_ID_Write=1 and ID_EX_Bubble=0.

Flush:
- IF_ID_Flush = branch_taken & ~stall.
- branch_taken is masked in any stall cycle, because operands are not final while stalled.
- A flush never changes PCWrite; the PC loads the branch target.

Counters:
- stall_count increments in every stall cycle. flush_count increments in every flush cycle.
- Both saturate at all-ones and never wrap.

## Timing
- Stall and flush outputs are Mealy: they are combinational from the opcodes, the state and branch_taken in the same cycle. No extra latency.
- Load followed by CBZ: exactly 2 stall cycles (RUN, then STALL). CBZ evaluates in the third cycle, with the load in WB.
- The state register and both counters reset asynchronously to RUN, 0 and 0.
- While reset=1, the outputs are forced to PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, IF_ID_Flush=0, stall_count=0 and flush_count=0.
- Reset asserted while in STALL returns the block to RUN immediately. Remaining is discarded.
- Counters are visible on the cycle after the increment, because they are registered.
- Hazard and branch_taken in the same cycle: the stall wins, there is no flush, and flush_count does not change.

## Structure
- cpu_pkg contains:
  - opcode constants: LDUR 11111000010, STUR 11111000000, CBZ [31:24]=10110100, B.cond [31:24]=01010100, B [31:26]=000101, BL [31:26]=100101, ADDS 10101011000, SUBS 11101011000
  - the instruction-format decode helpers
  - the FSM state enum {RUN, STALL}
  - the constant XZR = 5'd31
- One sub-module, sat_counter, parameterized by CNT_W, with inputs clk, reset and inc and a count output. It is instantiated twice.

## Test plan
- LDUR X1 in EX, ADD X2,X1,X3 in ID → 1 cycle with PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, then normal flow; stall_count=1.
- LDUR X5 in EX, CBZ X5 in ID → 2 consecutive stall cycles, state RUN→STALL→RUN; stall_count=2; with branch_taken=1 held throughout, flush is asserted only in the third cycle.
- LDUR X31 in EX, ADD reading X31 in ID → no stall, all outputs at their defaults.
- branch_taken=1 with no hazard → IF_ID_Flush=1 for that cycle only, PCWrite=1, flush_count=1.
- Reset pulse during the STALL cycle → outputs go to their reset values immediately; after release, state is RUN and both counters are 0.
- 65,540 forced stall cycles → stall_count holds at 0xFFFF.
